// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : shared T-state / bus-op types and M-cycle length
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   typedef enum logic [1:0] {
      T1 = 2'd0,
      T2 = 2'd1,
      T3 = 2'd2,
      T4 = 2'd3
   } tstate_e;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } bus_op_e;

   localparam int unsigned M_CYCLE_LEN = 4;

endpackage

`default_nettype wire

// File: rtl/cpu_bus_seq_if.sv
// ----------------------------------------------------------------------------
// cpu_bus_seq_if : core request/response and external bus bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cpu_bus_seq_if
   import cpu_pkg::*;
#(
   parameter int ADR_W = 16
);

   logic             req_valid;
   logic             req_write;
   logic [ADR_W-1:0] req_adr;
   logic [7:0]       req_dout;
   logic             req_ready;
   logic             rsp_valid;
   logic [7:0]       rsp_din;
   tstate_e          tstate;
   logic [ADR_W-1:0] adr;
   logic [7:0]       dout;
   logic [7:0]       din;
   logic             rd;
   logic             wr;

   // master: the sequencer itself; slave: the core plus external memory
   modport master (
      input  req_valid, req_write, req_adr, req_dout, din,
      output req_ready, rsp_valid, rsp_din, tstate, adr, dout, rd, wr
   );

   modport slave (
      output req_valid, req_write, req_adr, req_dout, din,
      input  req_ready, rsp_valid, rsp_din, tstate, adr, dout, rd, wr
   );

endinterface

`default_nettype wire

// File: rtl/cpu_tcyc_cnt.sv
// ----------------------------------------------------------------------------
// cpu_tcyc_cnt : free-running T1..T4 wrap counter with T4 strobe
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_tcyc_cnt
   import cpu_pkg::*;
(
   input  wire logic clk,
   input  wire logic nreset,
   output tstate_e   tstate,
   output logic      t4_stb
);

   tstate_e t_q;
   tstate_e t_d;

   always_comb begin
      t_d = tstate_e'(t_q + 2'd1);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         t_q <= T1;
      end else begin
         t_q <= t_d;
      end
   end

   assign tstate = t_q;
   assign t4_stb = (t_q == T4);

endmodule

`default_nettype wire

// File: rtl/cpu_bus_seq.sv
// ----------------------------------------------------------------------------
// cpu_bus_seq : four-T-state M-cycle bus sequencer (read / write / idle)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cpu_bus_seq
   import cpu_pkg::*;
#(
   parameter int ADR_W = 16
)(
   input wire logic      clk,
   input wire logic      nreset,
   cpu_bus_seq_if.master bus
);

   tstate_e          tstate;
   logic             t4_stb;

   bus_op_e          op_q,      op_d;
   logic [ADR_W-1:0] adr_q,     adr_d;
   logic [7:0]       wdata_q,   wdata_d;
   logic [7:0]       dout_q,    dout_d;
   logic [7:0]       rsp_din_q, rsp_din_d;

   cpu_tcyc_cnt u_tcyc (
      .clk    (clk),
      .nreset (nreset),
      .tstate (tstate),
      .t4_stb (t4_stb)
   );

   always_comb begin
      op_d      = op_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      dout_d    = dout_q;
      rsp_din_d = rsp_din_q;

      // Requests are only looked at on the edge that ends T4; an idle
      // M-cycle leaves the address register untouched so adr holds.
      if (t4_stb) begin
         if (!bus.req_valid) begin
            op_d = OP_IDLE;
         end else begin
            op_d    = bus.req_write ? OP_WRITE : OP_READ;
            adr_d   = bus.req_adr;
            wdata_d = bus.req_dout;
         end
      end

      // Write data appears from T2 on, so T1 of a write still shows the old value.
      if (op_q == OP_WRITE && tstate == T1) begin
         dout_d = wdata_q;
      end

      if (op_q == OP_READ && tstate == T3) begin
         rsp_din_d = bus.din;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         op_q      <= OP_IDLE;
         adr_q     <= '0;
         wdata_q   <= '0;
         dout_q    <= '0;
         rsp_din_q <= '0;
      end else begin
         op_q      <= op_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         dout_q    <= dout_d;
         rsp_din_q <= rsp_din_d;
      end
   end

   // Strobes decode only from reset-cleared flops, so reset kills them at once.
   assign bus.tstate    = tstate;
   assign bus.req_ready = t4_stb;
   assign bus.adr       = adr_q;
   assign bus.dout      = dout_q;
   assign bus.rsp_din   = rsp_din_q;
   assign bus.rd        = (op_q == OP_READ)  && (tstate != T4);
   assign bus.wr        = (op_q == OP_WRITE) && (tstate == T2 || tstate == T3);
   assign bus.rsp_valid = (op_q == OP_READ)  && (tstate == T4);

endmodule

`default_nettype wire
